mux_scan_nx1: RTL and testbench
===============================

MUX_SCAN_NX1 -- requirements
Module: mux_scan_nx1

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have parameter WIDTH, 1, bit width of each data channel (>=1).
REQ-002 SHALL have parameter CHANNELS, 4, number of input channels (power of two, >=2); SEL_W = log2(CHANNELS).
REQ-003 SHALL have parameter INVERT, 1, when 1 the output is the bitwise complement of the selected channel; when 0 it is a true copy.
REQ-004 SHALL have parameter DWELL, 1, enabled cycles each channel is presented in scan mode (>=1).

Ports (name, direction, width, meaning):
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port d, input, CHANNELS*WIDTH, flattened data; channel k is d[k*WIDTH +: WIDTH].
REQ-008 SHALL have port s, input, SEL_W, manual channel select.
REQ-009 SHALL have port load, input, 1, manual-mode strobe to latch s into the select register.
REQ-010 SHALL have port mode, input, 1: 0 = MANUAL, 1 = SCAN.
REQ-011 SHALL have port en, input, 1, sample enable.
REQ-012 SHALL have port result, output, WIDTH, registered selected (optionally inverted) data.
REQ-013 SHALL have port ch, output, SEL_W, channel index that produced result.
REQ-014 SHALL have port valid, output, 1, result/ch updated on the last edge.
REQ-015 SHALL have port wrap, output, 1, one-cycle pulse when scan index wraps CHANNELS-1 -> 0.

Function
REQ-016 SHALL hold internal select register sel (SEL_W bits), dwell counter dcnt (0..DWELL-1), and state in {MANUAL, SCAN}.
REQ-017 State SHALL follow mode each cycle: mode=0 -> MANUAL, mode=1 -> SCAN, transition taking effect on the next edge; sel is retained across transitions (scan resumes from current sel; manual holds last scanned sel).
REQ-018 On a mode change, dcnt SHALL clear to 0.
REQ-019 MANUAL: load=1 SHALL set sel <= s on that edge, independent of en; load=0 holds sel.
REQ-020 MANUAL: the sample taken on an edge SHALL use sel as it was before that edge (load takes effect for the following sample).
REQ-021 SCAN: load SHALL be ignored.
REQ-022 SCAN with en=1: dcnt increments; when dcnt = DWELL-1, dcnt <= 0 and sel <= sel+1 modulo CHANNELS; with en=0, sel and dcnt hold.
REQ-023 wrap SHALL be 1 for exactly the cycle after the edge on which SCAN sel advanced from CHANNELS-1 to 0; otherwise 0.
REQ-024 On each edge with en=1: result <= d[sel] (complemented if INVERT=1), ch <= sel (pre-edge value), valid <= 1; latency one clock from d/sel to result.
REQ-025 On each edge with en=0: result and ch SHALL hold, valid <= 0.
REQ-026 Output SHALL be purely a function of registered sel and sampled d; no combinational path from any input to any output.

Reset
REQ-027 reset=1 at an edge SHALL force sel=0, dcnt=0, state=MANUAL, result=0, ch=0, valid=0, wrap=0, overriding en, load and mode that cycle.
REQ-028 Reset mid-scan SHALL abandon the dwell count; after release, scanning restarts from channel 0 with a full DWELL period.
REQ-029 The first edge after reset release with en=1 SHALL sample channel 0.

Verification (WIDTH=4, CHANNELS=4, INVERT=1, DWELL=1 unless stated)
REQ-030 Manual select: d={3:0xC,2:0x5,1:0xA,0:0x3}, mode=0, load=1 s=2 one cycle, then en=1 -> next sample result=0xA (~0x5), ch=2, valid=1.
REQ-031 Scan sweep: same d, mode=1, en=1 from reset -> result 0xC,0x5,0xA,0x3,0xC..., ch 0,1,2,3,0; wrap=1 only in the cycle after ch=3 is sampled.
REQ-032 Enable gating: in SCAN, drop en for 3 cycles at ch=1 -> valid=0, result/ch hold at ch=1 data; on resume next ch=2, no channel skipped.
REQ-033 Dwell: DWELL=3, INVERT=0, scan -> each ch repeated 3 consecutive valid samples, wrap once per 12 enabled cycles.
REQ-034 Mode/load collision and reset: in SCAN assert load=1 s=3 at ch=1 -> ignored, next ch=2; then reset=1 mid-dwell -> all outputs 0 next cycle, restart at ch=0.

Source files
------------

// File: rtl/mux_scan_nx1.sv
// N:1 registered multiplexer with manual select and free-running scan mode.
// In scan mode the select register steps through every channel, holding each
// for DWELL enabled cycles; wrap pulses once per full sweep.
module mux_scan_nx1 #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    parameter int INVERT   = 1,
    parameter int DWELL    = 1,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [SEL_W-1:0]          s,
    input  logic                      load,
    input  logic                      mode,
    input  logic                      en,
    output logic [WIDTH-1:0]          result,
    output logic [SEL_W-1:0]          ch,
    output logic                      valid,
    output logic                      wrap
);

    localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(CHANNELS - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d, dcnt_eff;
    logic               wrap_d;
    logic [WIDTH-1:0]   chan [CHANNELS];
    logic [WIDTH-1:0]   sample;

    // Unflatten the data bus and form the (optionally inverted) sample.
    always_comb begin
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            chan[k] = d[k*WIDTH +: WIDTH];
        end
        sample = (INVERT != 0) ? ~chan[sel_q] : chan[sel_q];
    end

    // Next-state logic: state tracks mode; the edge where mode changes already
    // behaves as the new mode, but with the dwell count treated as cleared.
    always_comb begin
        state_d  = mode ? SCAN : MANUAL;
        sel_d    = sel_q;
        wrap_d   = 1'b0;
        dcnt_eff = (state_d != state_q) ? '0 : dcnt_q;
        dcnt_d   = dcnt_eff;
        case (state_d)
            MANUAL: begin
                if (load) begin
                    sel_d = s;
                end
            end
            SCAN: begin
                if (en) begin
                    if (dcnt_eff == DCNT_LAST) begin
                        dcnt_d = '0;
                        sel_d  = sel_q + 1'b1;
                        wrap_d = (sel_q == SEL_LAST);
                    end else begin
                        dcnt_d = dcnt_eff + 1'b1;
                    end
                end
            end
            default: begin
                sel_d = sel_q;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MANUAL;
            sel_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Output registers: sample with the pre-edge select when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            ch     <= '0;
            valid  <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            valid <= en;
            wrap  <= wrap_d;
            if (en) begin
                result <= sample;
                ch     <= sel_q;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed testbench for mux_scan_nx1: one inverting DWELL=1 instance and one
// true-copy DWELL=3 instance driven by the same stimulus.
module tb_mux_scan_nx1;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] d;
    logic [1:0]  s;
    logic        load, mode, en;

    logic [3:0]  result1, result3;
    logic [1:0]  ch1, ch3;
    logic        valid1, valid3, wrap1, wrap3;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected outputs per channel for d = {C,5,A,3}.
    logic [3:0] exp_inv  [4] = '{4'hC, 4'h5, 4'hA, 4'h3};
    logic [3:0] exp_copy [4] = '{4'h3, 4'hA, 4'h5, 4'hC};

    always #5 clk = ~clk;

    mux_scan_nx1 #(.WIDTH(4), .CHANNELS(4), .INVERT(1), .DWELL(1)) dut (
        .clk(clk), .reset(reset), .d(d), .s(s), .load(load), .mode(mode), .en(en),
        .result(result1), .ch(ch1), .valid(valid1), .wrap(wrap1)
    );

    mux_scan_nx1 #(.WIDTH(4), .CHANNELS(4), .INVERT(0), .DWELL(3)) dut3 (
        .clk(clk), .reset(reset), .d(d), .s(s), .load(load), .mode(mode), .en(en),
        .result(result3), .ch(ch3), .valid(valid3), .wrap(wrap3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic [3:0] r, input logic [1:0] c,
                          input logic v, input logic w);
        check({tag, ".result"}, 32'(result1), 32'(r));
        check({tag, ".ch"},     32'(ch1),     32'(c));
        check({tag, ".valid"},  32'(valid1),  32'(v));
        check({tag, ".wrap"},   32'(wrap1),   32'(w));
    endtask

    task automatic check3(input string tag, input logic [3:0] r, input logic [1:0] c,
                          input logic v, input logic w);
        check({tag, ".result"}, 32'(result3), 32'(r));
        check({tag, ".ch"},     32'(ch3),     32'(c));
        check({tag, ".valid"},  32'(valid3),  32'(v));
        check({tag, ".wrap"},   32'(wrap3),   32'(w));
    endtask

    // Advance one clock; outputs are settled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; d = 16'hC5A3; s = 2'd0; load = 1'b0; mode = 1'b0; en = 1'b0;
        step(); step();
        check1("rst", 4'h0, 2'd0, 1'b0, 1'b0);
        check3("rst3", 4'h0, 2'd0, 1'b0, 1'b0);

        // Manual load of channel 2, then sample it.
        reset = 1'b0; load = 1'b1; s = 2'd2;
        step();
        check("man_load.valid", 32'(valid1), 32'd0);
        load = 1'b0; en = 1'b1;
        step();
        check1("man_ch2", 4'hA, 2'd2, 1'b1, 1'b0);
        // Load and sample on the same edge: sample still uses old select.
        load = 1'b1; s = 2'd1;
        step();
        check1("man_same_edge", 4'hA, 2'd2, 1'b1, 1'b0);
        load = 1'b0;
        step();
        check1("man_ch1", 4'h5, 2'd1, 1'b1, 1'b0);

        // Scan sweep from reset.
        reset = 1'b1; en = 1'b0;
        step();
        reset = 1'b0; mode = 1'b1; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check1($sformatf("sweep%0d", i), exp_inv[i % 4], 2'(i % 4), 1'b1, (i == 3));
        end

        // Enable gating at ch=1.
        step();
        check1("gate_ch1", 4'h5, 2'd1, 1'b1, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check1($sformatf("gate_hold%0d", i), 4'h5, 2'd1, 1'b0, 1'b0);
        end
        en = 1'b1;
        step();
        check1("gate_resume", 4'hA, 2'd2, 1'b1, 1'b0);
        step();
        check1("gate_ch3", 4'h3, 2'd3, 1'b1, 1'b1);
        step();
        step();
        check1("pre_load_ch1", 4'h5, 2'd1, 1'b1, 1'b0);

        // Load is ignored in scan mode.
        load = 1'b1; s = 2'd0;
        step();
        check1("scan_load_ch2", 4'hA, 2'd2, 1'b1, 1'b0);
        load = 1'b0;
        step();
        check1("scan_load_ch3", 4'h3, 2'd3, 1'b1, 1'b1);

        // Reset mid-scan, then restart from channel 0.
        reset = 1'b1;
        step();
        check1("mid_rst", 4'h0, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        check1("restart", 4'hC, 2'd0, 1'b1, 1'b0);

        // Return to manual mode: select holds the last scanned channel.
        mode = 1'b0;
        step();
        check1("man_hold_a", 4'h5, 2'd1, 1'b1, 1'b0);
        step();
        check1("man_hold_b", 4'h5, 2'd1, 1'b1, 1'b0);

        // DWELL=3 instance: each channel three samples, wrap once per 12.
        reset = 1'b1;
        step();
        reset = 1'b0; mode = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            check3($sformatf("dwell%0d", i), exp_copy[(i / 3) % 4], 2'((i / 3) % 4),
                   1'b1, (i == 11));
        end

        // Mid-dwell reset: after release, channel 0 gets a full dwell period.
        step();
        check3("dwell_mid", 4'h3, 2'd0, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        check3("dwell_rst", 4'h0, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check3($sformatf("dwell_re%0d", i), (i < 3) ? 4'h3 : 4'hA,
                   (i < 3) ? 2'd0 : 2'd1, 1'b1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
